// File: rtl/ifetch_pkg.sv
// Shared fetch-stage types: bus widths, FSM encoding and the IF/ID hand-off record.
package ifetch_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } ifetch_state_t;

    localparam u32 NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic valid;
        u64   pc;
        u32   instr;
        logic exc;
    } fetch_data_t;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage signal bundle: PC register, instruction bus and decode hand-off.
interface ifetch_if;
    import ifetch_pkg::*;

    u64   pc;
    logic pc_write;
    logic flush;
    logic ireq_valid;
    u64   ireq_addr;
    logic iresp_data_ok;
    u32   iresp_data;
    logic out_valid;
    logic out_ready;
    u64   out_pc;
    u32   out_instr;
    logic out_exc;

    modport master (
        input  pc, flush, iresp_data_ok, iresp_data, out_ready,
        output pc_write, ireq_valid, ireq_addr, out_valid, out_pc, out_instr, out_exc
    );

    modport slave (
        output pc, flush, iresp_data_ok, iresp_data, out_ready,
        input  pc_write, ireq_valid, ireq_addr, out_valid, out_pc, out_instr, out_exc
    );

endinterface

// File: rtl/ifetch.sv
// Single-outstanding instruction fetch: sample PC, request, buffer the word for decode,
// and advance the PC only on decode accept. Redirect flush drops the current fetch.
module ifetch
    import ifetch_pkg::*;
(
    input logic     clk,
    input logic     reset,
    ifetch_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    u64          pc_q, pc_d;
    u32          instr_q, instr_d;
    logic        exc_q, exc_d;
    fetch_data_t fetch;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.flush) begin
                    pc_d = bus.pc;
                    if (bus.pc[1:0] == 2'b00) begin
                        state_d = S_REQ;
                    end else begin
                        // Misaligned PC never reaches the bus; decode sees a NOP tagged as an exception.
                        instr_d = NOP_INSTR;
                        exc_d   = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_REQ: begin
                if (bus.iresp_data_ok) begin
                    if (bus.flush) begin
                        state_d = S_IDLE;
                    end else begin
                        instr_d = bus.iresp_data;
                        exc_d   = 1'b0;
                        state_d = S_HOLD;
                    end
                end else if (bus.flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The request cannot be withdrawn; wait for its data and throw it away.
                if (bus.iresp_data_ok) state_d = S_IDLE;
            end
            S_HOLD: begin
                if (bus.flush || bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
        end
    end

    assign fetch = '{valid: (state_q == S_HOLD), pc: pc_q, instr: instr_q, exc: exc_q};

    // The latched PC doubles as the bus address and the PC handed to decode.
    assign bus.ireq_valid = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign bus.ireq_addr  = pc_q;
    assign bus.out_valid  = fetch.valid;
    assign bus.out_pc     = fetch.pc;
    assign bus.out_instr  = fetch.instr;
    assign bus.out_exc    = fetch.exc;
    assign bus.pc_write   = fetch.valid && bus.out_ready && !bus.flush;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios with literal expectations plus a random run
// checked every cycle against a transaction-level model of the fetch slot.
module tb_ifetch;
    import ifetch_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ifetch_if bus();

    ifetch dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Model: a request may be outstanding (possibly marked for discard), or one word is buffered.
    logic m_req, m_drop, m_buf, m_exc;
    u64   m_addr;
    u32   m_instr;

    task automatic model_reset();
        m_req = 0; m_drop = 0; m_buf = 0; m_exc = 0; m_addr = '0; m_instr = '0;
    endtask

    task automatic model_step();
        if (m_buf) begin
            if (bus.flush || bus.out_ready) m_buf = 0;
        end else if (m_req) begin
            if (bus.iresp_data_ok) begin
                if (!m_drop && !bus.flush) begin
                    m_buf = 1; m_instr = bus.iresp_data; m_exc = 0;
                end
                m_req = 0; m_drop = 0;
            end else if (bus.flush) begin
                m_drop = 1;
            end
        end else if (!bus.flush) begin
            m_addr = bus.pc;
            if (bus.pc[1:0] == 2'b00) m_req = 1;
            else begin m_buf = 1; m_instr = NOP_INSTR; m_exc = 1; end
        end
    endtask

    initial model_reset();
    always @(negedge reset) model_reset();
    always begin
        @(posedge clk);
        if (reset) model_step();
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            chk("m_ireq_valid", {63'd0, bus.ireq_valid}, {63'd0, m_req});
            chk("m_out_valid", {63'd0, bus.out_valid}, {63'd0, m_buf});
            chk("m_pc_write", {63'd0, bus.pc_write},
                {63'd0, m_buf && bus.out_ready && !bus.flush});
            if (m_req) chk("m_ireq_addr", bus.ireq_addr, m_addr);
            if (m_buf) begin
                chk("m_out_pc", bus.out_pc, m_addr);
                chk("m_out_instr", {32'd0, bus.out_instr}, {32'd0, m_instr});
                chk("m_out_exc", {63'd0, bus.out_exc}, {63'd0, m_exc});
            end
        end
    end

    task automatic drive(input u64 pc, input logic fl, input logic dok, input u32 data, input logic rdy);
        @(negedge clk);
        bus.pc = pc; bus.flush = fl; bus.iresp_data_ok = dok; bus.iresp_data = data; bus.out_ready = rdy;
        #2;
    endtask

    task automatic park();
        drive(64'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    localparam u64 P0 = 64'h8000_0000;
    localparam u64 P1 = 64'h8000_0004;
    localparam u64 P2 = 64'h8000_0008;
    localparam u64 P3 = 64'h8000_0100;
    localparam u64 P4 = 64'h8000_0200;
    localparam u64 P5 = 64'h8000_0002;
    localparam u64 P6 = 64'h8000_0300;

    initial begin
        bus.pc = '0; bus.flush = 1'b1; bus.iresp_data_ok = 1'b0; bus.iresp_data = '0; bus.out_ready = 1'b0;
        #12;
        chk("rst_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_exc", {63'd0, bus.out_exc}, 64'd0);
        chk("rst_pc_write", {63'd0, bus.pc_write}, 64'd0);
        chk("rst_ireq_addr", bus.ireq_addr, 64'd0);
        chk("rst_out_pc", bus.out_pc, 64'd0);
        chk("rst_out_instr", {32'd0, bus.out_instr}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic fetch, data two cycles after the request rises.
        drive(P0, 0, 0, 0, 0);
        chk("basic_idle_noreq", {63'd0, bus.ireq_valid}, 64'd0);
        drive(P0, 0, 0, 0, 0);
        chk("basic_ireq", {63'd0, bus.ireq_valid}, 64'd1);
        chk("basic_addr", bus.ireq_addr, P0);
        drive(P0, 0, 0, 0, 0);
        drive(P0, 0, 1, 32'h0000_0513, 0);
        chk("basic_ireq_held", {63'd0, bus.ireq_valid}, 64'd1);
        drive(P0, 0, 0, 0, 0);
        chk("basic_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("basic_out_pc", bus.out_pc, P0);
        chk("basic_out_instr", {32'd0, bus.out_instr}, 64'h0000_0513);
        chk("basic_out_exc", {63'd0, bus.out_exc}, 64'd0);
        drive(P0, 0, 0, 0, 1);
        chk("basic_pc_write", {63'd0, bus.pc_write}, 64'd1);
        park();
        chk("basic_pc_write_once", {63'd0, bus.pc_write}, 64'd0);
        chk("basic_idle_out", {63'd0, bus.out_valid}, 64'd0);

        // Backpressure in HOLD.
        drive(P1, 0, 0, 0, 0);
        drive(P1, 0, 1, 32'h00A0_0093, 0);
        for (int i = 0; i < 5; i++) begin
            drive(P1, 0, 0, 0, 0);
            chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp_out_instr", {32'd0, bus.out_instr}, 64'h00A0_0093);
            chk("bp_no_pc_write", {63'd0, bus.pc_write}, 64'd0);
            chk("bp_no_req", {63'd0, bus.ireq_valid}, 64'd0);
        end
        drive(P1, 0, 0, 0, 1);
        chk("bp_pc_write", {63'd0, bus.pc_write}, 64'd1);
        park();

        // Flush in REQ without data: drain, discard, refetch at the new PC.
        drive(P2, 0, 0, 0, 0);
        drive(P2, 1, 0, 0, 0);
        chk("drain_addr0", bus.ireq_addr, P2);
        drive(P3, 0, 0, 0, 0);
        chk("drain_ireq", {63'd0, bus.ireq_valid}, 64'd1);
        chk("drain_addr1", bus.ireq_addr, P2);
        drive(P3, 0, 0, 0, 0);
        drive(P3, 0, 1, 32'hDEAD_BEEF, 0);
        chk("drain_addr3", bus.ireq_addr, P2);
        chk("drain_no_out", {63'd0, bus.out_valid}, 64'd0);
        drive(P3, 0, 0, 0, 0);
        chk("drain_discard", {63'd0, bus.out_valid}, 64'd0);
        chk("drain_idle", {63'd0, bus.ireq_valid}, 64'd0);
        drive(P3, 0, 0, 0, 0);
        chk("refetch_addr", bus.ireq_addr, P3);
        drive(P3, 0, 1, 32'h1234_5678, 0);
        drive(P3, 1, 0, 0, 1);
        chk("flush_rdy_no_pc_write", {63'd0, bus.pc_write}, 64'd0);
        park();
        chk("flush_rdy_idle", {63'd0, bus.out_valid}, 64'd0);

        // Flush together with data_ok in REQ.
        drive(P4, 0, 0, 0, 0);
        drive(P4, 1, 1, 32'hCAFE_F00D, 0);
        drive(P4, 1, 0, 0, 0);
        chk("flush_dok_dropped", {63'd0, bus.out_valid}, 64'd0);
        chk("flush_dok_idle", {63'd0, bus.ireq_valid}, 64'd0);

        // Misaligned PC.
        drive(P5, 0, 0, 0, 0);
        drive(P5, 0, 0, 0, 0);
        chk("mis_no_req", {63'd0, bus.ireq_valid}, 64'd0);
        chk("mis_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("mis_exc", {63'd0, bus.out_exc}, 64'd1);
        chk("mis_instr", {32'd0, bus.out_instr}, 64'h0000_0013);
        chk("mis_pc", bus.out_pc, P5);
        drive(P5, 0, 0, 0, 1);
        chk("mis_pc_write", {63'd0, bus.pc_write}, 64'd1);
        park();

        // Asynchronous reset mid-REQ.
        drive(P6, 0, 0, 0, 0);
        drive(P6, 0, 0, 0, 0);
        chk("arst_pre_req", {63'd0, bus.ireq_valid}, 64'd1);
        reset = 1'b0;
        #1;
        chk("arst_ireq_drop", {63'd0, bus.ireq_valid}, 64'd0);
        chk("arst_out_drop", {63'd0, bus.out_valid}, 64'd0);
        chk("arst_addr_clr", bus.ireq_addr, 64'd0);
        @(negedge clk);
        bus.flush = 1'b1;
        reset = 1'b1;
        drive(P6, 1, 0, 0, 0);
        chk("arst_idle", {63'd0, bus.ireq_valid}, 64'd0);

        // Random traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.pc            = {32'h8000_0000, $urandom} & (($urandom_range(0, 5) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                                                       : 64'hFFFF_FFFF_FFFF_FFFC);
            bus.flush         = ($urandom_range(0, 7) == 0);
            bus.iresp_data_ok = ($urandom_range(0, 2) == 0);
            bus.iresp_data    = $urandom;
            bus.out_ready     = ($urandom_range(0, 1) == 0);
        end
        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
